// File: rtl/fpu_norm_pkg.sv
// fpu_norm_pkg: widths and bit positions shared by the mantissa normalizer
package fpu_norm_pkg;
  localparam int MAN_W   = 32;
  localparam int EXP_W   = 10;
  localparam int LZ_W    = $clog2(MAN_W);
  localparam int EXP_MAX = 255;
  localparam int SIG_MSB = 31;
  localparam int SIG_LSB = 24;
  localparam int G_BIT   = 23;
  localparam int R_BIT   = 22;
  localparam int S_MSB   = 21;
endpackage

// File: rtl/fpu_lzd_normalizer_if.sv
// fpu_lzd_normalizer_if: input and output handshake bundle of the normalizer
interface fpu_lzd_normalizer_if;
  import fpu_norm_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic [LZ_W-1:0]  lzd_pos;
  logic             lzd_valid;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [7:0]       out_man;
  logic [2:0]       out_grs;
  logic             out_zero;
  logic             out_uflow;
  logic             out_oflow;
  modport master (
    output in_valid, in_sign, in_exp, in_man, lzd_pos, lzd_valid, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_man, out_grs, out_zero, out_uflow, out_oflow
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_man, lzd_pos, lzd_valid, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_man, out_grs, out_zero, out_uflow, out_oflow
  );
endinterface

// File: rtl/fpu_norm_lshift.sv
// fpu_norm_lshift: logarithmic left barrel shifter, one level per amount bit
module fpu_norm_lshift
  import fpu_norm_pkg::*;
(
  input  logic [MAN_W-1:0] din,
  input  logic [LZ_W-1:0]  amt,
  output logic [MAN_W-1:0] dout
);
  logic [MAN_W-1:0] lvl [LZ_W+1];
  assign lvl[0] = din;
  for (genvar i = 0; i < LZ_W; i++) begin : g_lvl
    assign lvl[i+1] = amt[i] ? lvl[i] << (1 << i) : lvl[i];
  end
  assign dout = lvl[LZ_W];
endmodule

// File: rtl/fpu_lzd_normalizer.sv
// fpu_lzd_normalizer: two-stage normalizer applying the LZD count to the mantissa
// and exponent, producing a BF16 significand with guard/round/sticky.
module fpu_lzd_normalizer
  import fpu_norm_pkg::*;
(
  input logic           clk,
  input logic           rst_l,
  fpu_lzd_normalizer_if.slave bus
);
  logic             a_valid, a_sign, a_zero;
  logic [EXP_W-1:0] a_exp, exp_adj;
  logic [MAN_W-1:0] a_man, sh;
  logic [LZ_W-1:0]  a_lz;
  logic             b_adv, in_fire;
  assign b_adv       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !a_valid || b_adv;
  assign in_fire     = bus.in_valid && bus.in_ready;
  assign exp_adj     = a_exp + EXP_W'(1) - EXP_W'(a_lz);
  fpu_norm_lshift u_lshift (.din(a_man), .amt(a_lz), .dout(sh));
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      a_valid       <= 1'b0;
      a_sign        <= 1'b0;
      a_zero        <= 1'b0;
      a_exp         <= '0;
      a_man         <= '0;
      a_lz          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sign  <= 1'b0;
      bus.out_exp   <= '0;
      bus.out_man   <= '0;
      bus.out_grs   <= '0;
      bus.out_zero  <= 1'b0;
      bus.out_uflow <= 1'b0;
      bus.out_oflow <= 1'b0;
    end else begin
      if (in_fire) begin
        a_valid <= 1'b1;
        a_sign  <= bus.in_sign;
        a_zero  <= !bus.lzd_valid;
        a_exp   <= bus.in_exp;
        a_man   <= bus.in_man;
        a_lz    <= bus.lzd_pos;
      end else if (b_adv) begin
        a_valid <= 1'b0;
      end
      if (b_adv) begin
        bus.out_valid <= a_valid;
        if (a_valid) begin
          // zero results keep the sign but clear all data and range flags
          bus.out_sign  <= a_sign;
          bus.out_exp   <= a_zero ? '0 : exp_adj;
          bus.out_man   <= a_zero ? '0 : sh[SIG_MSB:SIG_LSB];
          bus.out_grs   <= a_zero ? '0 : {sh[G_BIT], sh[R_BIT], |sh[S_MSB:0]};
          bus.out_zero  <= a_zero;
          bus.out_uflow <= !a_zero && ($signed(exp_adj) <= 0);
          bus.out_oflow <= !a_zero && ($signed(exp_adj) >= EXP_MAX);
        end
      end
    end
  end
endmodule

// File: tb/tb_fpu_lzd_normalizer.sv
// tb_fpu_lzd_normalizer: directed table, backpressure, reset and random scoreboard tests
module tb_fpu_lzd_normalizer;
  typedef logic [24:0] ov_t;
  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [31:0] man;
    logic [4:0]  lz;
    logic        lzv;
    logic [9:0]  e_exp;
    logic [7:0]  e_man;
    logic [2:0]  e_grs;
    logic [2:0]  e_flg;
  } vec_t;

  logic clk, rst_l;
  int   checks, errors;
  ov_t  q[$];
  vec_t vec[13];
  ov_t  snap;

  fpu_lzd_normalizer_if bus();
  fpu_lzd_normalizer dut (.clk(clk), .rst_l(rst_l), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ov_t model(logic sign, logic [9:0] exp, logic [31:0] man, logic [4:0] lz, logic lzv);
    logic [31:0] sh;
    logic [9:0]  e;
    sh = man << lz;
    e  = exp + 10'd1 - {5'd0, lz};
    if (!lzv) return {sign, 10'd0, 8'd0, 3'd0, 3'b100};
    return {sign, e, sh[31:24], sh[23], sh[22], |sh[21:0], 1'b0, $signed(e) <= 0, $signed(e) >= 255};
  endfunction

  function automatic ov_t outs();
    return {bus.out_sign, bus.out_exp, bus.out_man, bus.out_grs, bus.out_zero, bus.out_uflow, bus.out_oflow};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic sign, logic [9:0] exp, logic [31:0] man, logic [4:0] lz, logic lzv);
    bus.in_valid  = v;
    bus.in_sign   = sign;
    bus.in_exp    = exp;
    bus.in_man    = man;
    bus.lzd_pos   = lz;
    bus.lzd_valid = lzv;
  endtask

  // advance one cycle; handshakes are observed at the falling edge before the fire
  task automatic tick();
    @(negedge clk);
    if (rst_l) begin
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.in_sign, bus.in_exp, bus.in_man, bus.lzd_pos, bus.lzd_valid));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("unexpected_beat", 32'(outs()), 32'hFFFF_FFFF);
        else check("scoreboard", 32'(outs()), 32'(q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vec[0]  = '{1'b0, 10'd127,  32'h4000_0000, 5'd1,  1'b1, 10'd127,  8'h80, 3'b000, 3'b000};
    vec[1]  = '{1'b1, 10'd127,  32'h8000_0000, 5'd0,  1'b1, 10'd128,  8'h80, 3'b000, 3'b000};
    vec[2]  = '{1'b0, 10'd40,   32'h0000_0001, 5'd31, 1'b1, 10'd10,   8'h80, 3'b000, 3'b000};
    vec[3]  = '{1'b0, 10'd100,  32'h4080_0001, 5'd1,  1'b1, 10'd100,  8'h81, 3'b001, 3'b000};
    vec[4]  = '{1'b0, 10'd5,    32'h0020_0000, 5'd10, 1'b1, 10'h3FC,  8'h80, 3'b000, 3'b010};
    vec[5]  = '{1'b0, 10'd254,  32'h8000_0000, 5'd0,  1'b1, 10'd255,  8'h80, 3'b000, 3'b001};
    vec[6]  = '{1'b1, 10'd77,   32'h0000_0000, 5'd0,  1'b0, 10'd0,    8'h00, 3'b000, 3'b100};
    vec[7]  = '{1'b0, 10'd30,   32'h0000_01FF, 5'd23, 1'b1, 10'd8,    8'hFF, 3'b100, 3'b000};
    vec[8]  = '{1'b0, 10'd20,   32'h0000_3FFF, 5'd18, 1'b1, 10'd3,    8'hFF, 3'b111, 3'b000};
    vec[9]  = '{1'b0, 10'd0,    32'h4000_0000, 5'd1,  1'b1, 10'd0,    8'h80, 3'b000, 3'b010};
    vec[10] = '{1'b0, 10'd253,  32'h8000_0000, 5'd0,  1'b1, 10'd254,  8'h80, 3'b000, 3'b000};
    vec[11] = '{1'b0, 10'h3F0,  32'h0000_00A5, 5'd24, 1'b1, 10'h3D9,  8'hA5, 3'b000, 3'b010};
    vec[12] = '{1'b0, 10'd50,   32'h0000_0203, 5'd22, 1'b1, 10'd29,   8'h80, 3'b110, 3'b000};

    rst_l = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_outputs", 32'(outs()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;
    tick();

    foreach (vec[i]) begin
      drive(1'b1, vec[i].sign, vec[i].exp, vec[i].man, vec[i].lz, vec[i].lzv);
      tick();
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
      check($sformatf("v%0d_latency1", i), 32'(bus.out_valid), 32'd0);
      tick();
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_data", i), 32'(outs()),
            32'({vec[i].sign, vec[i].e_exp, vec[i].e_man, vec[i].e_grs, vec[i].e_flg}));
    end
    repeat (3) tick();

    // backpressure: two beats fill the pipe, the third must wait
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 10'd60, 32'h0100_0000, 5'd7, 1'b1);
    tick();
    drive(1'b1, 1'b1, 10'd61, 32'h0000_8001, 5'd16, 1'b1);
    tick();
    drive(1'b1, 1'b0, 10'd62, 32'h0000_0000, 5'd0, 1'b0);
    check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    tick();
    check("bp_in_ready_hold", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    snap = outs();
    tick();
    check("bp_stable", 32'(outs()), 32'(snap));
    check("bp_first_beat", 32'(outs()), 32'(model(1'b0, 10'd60, 32'h0100_0000, 5'd7, 1'b1)));
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("bp_drained", 32'(q.size()), 32'd0);

    // reset with both stages full discards everything
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 10'd90, 32'h8000_0000, 5'd0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 10'd91, 32'h4000_0000, 5'd1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("rst_pre_full", 32'({bus.out_valid, bus.in_ready}), 32'b10);
    #2 rst_l = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.out_valid), 32'd0);
    check("rst_async_outputs", 32'(outs()), 32'd0);
    check("rst_async_in_ready", 32'(bus.in_ready), 32'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    bus.out_ready = 1'b1;
    check("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (4) tick();
    check("rst_no_stale", 32'(bus.out_valid), 32'd0);

    // random valid/ready against the scoreboard
    for (int c = 0; c < 400; c++) begin
      logic [4:0] lz;
      logic       z;
      lz = 5'($urandom_range(0, 31));
      z  = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom), 10'($urandom),
            z ? 32'd0 : (($urandom | 32'h8000_0000) >> lz), z ? 5'd0 : lz, !z);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) tick();
    check("random_drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_lzd_normalizer.md
# fpu_lzd_normalizer

Pipelined mantissa normalizer that consumes the leading-zero count produced by the FPU's 32-bit leading-zero detector and applies it. It left-shifts a raw 32-bit sum/product mantissa so the leading one lands at bit 31, then adjusts the exponent to match. It extracts the BF16 8-bit significand plus guard/round/sticky bits for the rounder. It sits between the LZD tree and the rounding stage, with a valid/ready handshake on both sides.

## Interface
Parameters:
- MAN_W, 32, raw mantissa width; LZD count width is $clog2(MAN_W) = 5
- EXP_W, 10, signed biased exponent width (two's complement)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_l  input  1  asynchronous, active-low reset
- in_valid  input  1  input beat offered
- in_ready  output  1  block accepts the beat this cycle
- in_sign  input  1  sign, passed through unchanged
- in_exp  input  EXP_W  signed biased exponent, with the binary point after bit 30 of in_man
- in_man  input  MAN_W  raw mantissa
- lzd_pos  input  5  leading-zero count of in_man (0..31)
- lzd_valid  input  1  1 when in_man is nonzero
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_sign  output  1  sign
- out_exp  output  EXP_W  adjusted exponent
- out_man  output  8  normalized significand, hidden bit at bit 7
- out_grs  output  3  {guard, round, sticky}
- out_zero, out_uflow, out_oflow  output  1 each  result flags

## Operation
- A beat fires on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
- Stage A captures sign, exponent, mantissa, shift amount lz = lzd_pos, and zero = !lzd_valid on an input fire.
- Stage B computes:
  - sh = in_man << lz
  - out_man = sh[31:24]
  - guard = sh[23], round = sh[22], sticky = |sh[21:0]
  - out_exp = in_exp + 1 - lz, in EXP_W-bit signed arithmetic with the lz operand zero-extended
- Flags:
  - zero: out_man, out_grs and out_exp are forced to 0 and out_zero = 1. uflow and oflow stay 0.
  - Otherwise out_uflow = (out_exp <= 0, signed) and out_oflow = (out_exp >= 255, signed). out_exp still carries the raw adjusted value so the rounder can denormalize or saturate.
- The block does not check lzd_pos against in_man. An inconsistent pair produces an undefined significand, but the handshake remains correct.
- Flow control:
  - b_adv = !b_valid || out_ready
  - in_ready = !a_valid || b_adv
  - Stage A loads on an input fire. Stage B loads from A when a_valid && b_adv.
  - A valid flag clears when its data advances without a refill.
- Order is preserved and no beat is dropped or duplicated under any backpressure pattern.

## Timing
- Latency: 2 cycles from input fire to out_valid when out_ready is held at 1. Throughput: 1 beat/cycle.
- While out_ready is low, at most 2 beats are held. in_ready drops only when both stages are full.
- in_ready is combinational from out_ready and the internal valids. It has no combinational path from in_valid.
- Output data is registered and holds stable while out_valid && !out_ready.
- Simultaneous output drain and input accept with both stages full is allowed: B takes A and A takes the new beat in the same cycle.
- Reset (asynchronous assert at any time, including mid-pipeline):
  - all valids are 0 and all output data and flags read 0
  - in_ready is 1 after reset
  - in-flight beats are discarded
- Deassertion is synchronized outside the block.

## Structure
- Shared package fpu_norm_pkg holds:
  - MAN_W, EXP_W, LZ_W
  - EXP_MAX = 255
  - the GRS bit-index constants
- One combinational sub-module, fpu_norm_lshift: a 5-level logarithmic left barrel shifter (32-bit in, 5-bit amount, 32-bit out). It is instantiated in stage B.
- The remainder is the two-stage register and handshake logic in fpu_lzd_normalizer.

## Test plan
- in_man=0x4000_0000, lz=1, exp=127 → out_exp=127, out_man=0x80, grs=000, no flags, out_valid 2 cycles after fire.
- in_man=0x8000_0000, lz=0, exp=127 → out_exp=128. in_man=0x0000_0001, lz=31, exp=40 → out_exp=10, out_man=0x80.
- in_man=0x4080_0001, lz=1, exp=100 → out_man=0x81, grs=001, out_exp=100.
- Flag cases:
  - exp=5, lz=10 → out_exp=0x3FC (−4), out_uflow=1
  - exp=254, lz=0 → out_exp=255, out_oflow=1
  - lzd_valid=0 → out_zero=1, all data 0
- Backpressure: hold out_ready=0 and offer 3 beats back-to-back → only 2 accepted, in_ready=0 on the third. Release out_ready → all beats emerge in order, none lost. Finish with random valid/ready against a scoreboard.
- Assert rst_l low with both stages full → outputs 0 immediately, in_ready=1 after release, no stale beat ever emerges.
